// File: rtl/program_sequencer_pkg.sv
// Shared opcode constants, FSM state type and decode helper for the program sequencer.
package program_sequencer_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] ULA_OP_MAX = 4'hC;
    localparam logic [3:0] OP_JMP     = 4'hD;
    localparam logic [3:0] OP_JZ      = 4'hE;
    localparam logic [3:0] OP_HLT     = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_FETCH_OP,
        ST_TARGET,
        ST_HALT
    } state_t;

    // True for opcodes that are forwarded to the ULA rather than handled locally.
    function automatic logic is_ula_op(input logic [3:0] op);
        return op <= ULA_OP_MAX;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear to RESET_PC, load, increment with natural wrap.
module program_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clockn,
    input  logic              Resetn,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadValue,
    output logic [ADDR_W-1:0] pc
);

    // Load has priority over increment; arithmetic wraps modulo 2**ADDR_W.
    always_ff @(posedge Clockn) begin
        if (!Resetn)
            pc <= RESET_PC;
        else if (load)
            pc <= loadValue;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions from a synchronous ROM, issues ALU ops
// to the ULA with a one-cycle active-low strobe and executes JMP/JZ/HLT locally.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clockn,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Passo,
    input  logic              flagZero,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [7:0]        romData,
    output logic [7:0]        barramentoDados,
    output logic              RegEnable,
    output logic              Halted,
    output logic [ADDR_W-1:0] ledsPC
);

    state_t            state;
    state_t            nextState;
    logic [3:0]        irOp;
    logic              pcInc;
    logic              pcLoad;
    logic [ADDR_W-1:0] pcLoadValue;
    logic [ADDR_W-1:0] pc;

    program_counter #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .Clockn   (Clockn),
        .Resetn   (Resetn),
        .inc      (pcInc),
        .load     (pcLoad),
        .loadValue(pcLoadValue),
        .pc       (pc)
    );

    assign romAddr   = pc;
    assign RegEnable = (state != ST_ISSUE);
    assign Halted    = (state == ST_HALT);

    // Next-state and PC control; DECODE looks at romData directly since IR loads on the same edge.
    always_comb begin
        nextState   = state;
        pcInc       = 1'b0;
        pcLoad      = 1'b0;
        pcLoadValue = romData[ADDR_W-1:0];
        case (state)
            ST_IDLE:     if (Start) nextState = ST_FETCH;
            ST_FETCH:    nextState = ST_DECODE;
            ST_DECODE: begin
                pcInc = 1'b1;
                if (is_ula_op(romData[7:4]))
                    nextState = ST_ISSUE;
                else if (romData[7:4] == OP_HLT)
                    nextState = ST_HALT;
                else
                    nextState = ST_FETCH_OP;
            end
            ST_ISSUE:    nextState = Passo ? ST_IDLE : ST_FETCH;
            ST_FETCH_OP: nextState = ST_TARGET;
            ST_TARGET: begin
                if (irOp == OP_JMP || flagZero)
                    pcLoad = 1'b1;
                else
                    pcInc = 1'b1;
                nextState = Passo ? ST_IDLE : ST_FETCH;
            end
            ST_HALT:     nextState = ST_HALT;
            default:     nextState = ST_IDLE;
        endcase
    end

    // State, opcode latch, held bus value and PC mirror.
    always_ff @(posedge Clockn) begin
        if (!Resetn) begin
            state           <= ST_IDLE;
            irOp            <= OP_NOP;
            barramentoDados <= '0;
            ledsPC          <= RESET_PC;
        end else begin
            state  <= nextState;
            ledsPC <= pc;
            if (state == ST_DECODE) begin
                irOp <= romData[7:4];
                if (is_ula_op(romData[7:4]))
                    barramentoDados <= romData;
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with a synchronous ROM model.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       Resetn, Start, Passo, flagZero;
    logic [7:0] romAddr, romData, bus, ledsPC;
    logic       RegEnable, Halted;
    logic [7:0] romAddrW, romDataW, busW, ledsPCW;
    logic       RegEnableW, HaltedW;
    logic [7:0] rom [0:255];

    int checks = 0;
    int failures = 0;
    int cyc;
    int ns, dbl, haltCyc, addr5;
    bit sawF0, prevLow;
    logic [7:0] sb [0:7];
    int         sc [0:7];
    logic [7:0] ledsAfter;

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the address.
    always @(posedge clk) begin
        romData  <= rom[romAddr];
        romDataW <= rom[romAddrW];
    end

    program_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .Clockn(clk), .Resetn(Resetn), .Start(Start), .Passo(Passo), .flagZero(flagZero),
        .romAddr(romAddr), .romData(romData), .barramentoDados(bus),
        .RegEnable(RegEnable), .Halted(Halted), .ledsPC(ledsPC)
    );

    program_sequencer #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_w (
        .Clockn(clk), .Resetn(Resetn), .Start(Start), .Passo(Passo), .flagZero(flagZero),
        .romAddr(romAddrW), .romData(romDataW), .barramentoDados(busW),
        .RegEnable(RegEnableW), .Halted(HaltedW), .ledsPC(ledsPCW)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_run();
        ns = 0; dbl = 0; haltCyc = -1; addr5 = -1; sawF0 = 0; prevLow = 0; ledsAfter = 8'hXX;
    endtask

    // Hold reset for two edges, check reset values, release with given Start level.
    task automatic do_reset(input logic st);
        Resetn = 1'b0; Start = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_regen", RegEnable, 1'b1);
        check("rst_halted", Halted, 1'b0);
        check("rst_bus", bus, 8'h00);
        check("rst_leds", ledsPC, 8'h00);
        check("rst_addr", romAddr, 8'h00);
        check("rst_leds_w", ledsPCW, 8'hFE);
        Resetn = 1'b1; Start = st;
        cyc = 0;
        clear_run();
    endtask

    task automatic run(input int n, input bit w);
        logic re, h;
        logic [7:0] b, l;
        for (int i = 0; i < n; i++) begin
            step();
            re = w ? RegEnableW : RegEnable;
            b  = w ? busW : bus;
            h  = w ? HaltedW : Halted;
            l  = w ? ledsPCW : ledsPC;
            if (cyc == 5) addr5 = w ? romAddrW : romAddr;
            if (ns > 0 && cyc == sc[0] + 1) ledsAfter = l;
            if (!re) begin
                if (prevLow) dbl++;
                if (ns < 8) begin sb[ns] = b; sc[ns] = cyc; end
                ns++;
            end
            prevLow = !re;
            if (b == 8'hF0) sawF0 = 1;
            if (h && haltCyc < 0) haltCyc = cyc;
        end
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; Passo = 1'b0; flagZero = 1'b0; cyc = 0;
        fill_rom();

        // Basic ALU issue then HLT
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'hF0;
        do_reset(1'b1);
        run(14, 0);
        check("alu_nstrobe", ns, 2);
        check("alu_cyc0", sc[0], 3);
        check("alu_bus0", sb[0], 8'h13);
        check("alu_cyc1", sc[1], 6);
        check("alu_bus1", sb[1], 8'h25);
        check("alu_halt_cyc", haltCyc, 9);
        check("alu_no_f0", sawF0, 1'b0);
        check("alu_no_dbl", dbl, 0);
        check("alu_halt_hold", Halted, 1'b1);
        check("alu_bus_hold", bus, 8'h25);

        // JMP to 0x10
        fill_rom();
        rom[0] = 8'hD0; rom[1] = 8'h10; rom[16] = 8'h17;
        do_reset(1'b1);
        run(12, 0);
        check("jmp_nstrobe", ns, 1);
        check("jmp_cyc", sc[0], 7);
        check("jmp_bus", sb[0], 8'h17);
        check("jmp_leds", ledsAfter, 8'h11);

        // JZ not taken / taken
        fill_rom();
        rom[0] = 8'hE0; rom[1] = 8'h40; rom[2] = 8'h13; rom[8'h40] = 8'h14;
        flagZero = 1'b0;
        do_reset(1'b1);
        run(12, 0);
        check("jz0_addr", addr5, 8'h02);
        check("jz0_bus", sb[0], 8'h13);
        check("jz0_cyc", sc[0], 7);
        flagZero = 1'b1;
        do_reset(1'b1);
        run(12, 0);
        check("jz1_addr", addr5, 8'h40);
        check("jz1_bus", sb[0], 8'h14);
        flagZero = 1'b0;

        // Single-step with Passo
        fill_rom();
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'hF0;
        Passo = 1'b1;
        do_reset(1'b1);
        step(); Start = 1'b0;
        run(10, 0);
        check("step1_n", ns, 1);
        check("step1_bus", sb[0], 8'h13);
        check("step1_addr", romAddr, 8'h01);
        check("step1_halted", Halted, 1'b0);
        clear_run();
        Start = 1'b1; step(); Start = 1'b0;
        run(10, 0);
        check("step2_n", ns, 1);
        check("step2_bus", sb[0], 8'h25);
        clear_run();
        Start = 1'b1; step(); Start = 1'b0;
        run(6, 0);
        check("step3_n", ns, 0);
        check("step3_halted", Halted, 1'b1);
        Passo = 1'b0;

        // PC wrap on the RESET_PC=FE instance
        fill_rom();
        rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h12; rom[0] = 8'hF0;
        do_reset(1'b1);
        run(14, 1);
        check("wrap_n", ns, 2);
        check("wrap_bus0", sb[0], 8'h11);
        check("wrap_bus1", sb[1], 8'h12);
        check("wrap_cyc1", sc[1], 6);
        check("wrap_halt_cyc", haltCyc, 9);

        // Reset asserted during ISSUE
        fill_rom();
        rom[0] = 8'h13; rom[1] = 8'h25;
        do_reset(1'b1);
        step(); step(); step();
        check("rstiss_strobe", RegEnable, 1'b0);
        Resetn = 1'b0; Start = 1'b0;
        step();
        check("rstiss_regen", RegEnable, 1'b1);
        check("rstiss_addr", romAddr, 8'h00);
        check("rstiss_leds", ledsPC, 8'h00);
        Resetn = 1'b1;
        clear_run();
        run(6, 0);
        check("rstiss_idle_n", ns, 0);
        check("rstiss_idle_addr", romAddr, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
